fc_argmax_classifier: RTL and testbench
=======================================

// Module: fc_argmax_classifier
// PURPOSE
//  Downstream of the FC output layer. Snapshots the NUM_CLASSES signed fixed-point output-neuron values on start.
//  Scans them serially, one per cycle, and reports the index of the largest as the final digit class.
//  Drives the FC top-level class output and done flag. Replaces the combinational softmax/argmax path.
// PARAMETERS
//  WORD_SIZE    16  width of one output-neuron value, two's complement fixed point
//  NUM_CLASSES  10  number of output neurons scanned (>=1)
//  CLASS_W      4   width of class index; must satisfy 2**CLASS_W >= NUM_CLASSES
// PORTS
//  clk        in   1                        single clock, rising edge
//  rst_n      in   1                        asynchronous, active-low reset
//  start      in   1                        1-cycle request from FC controller: output layer values are final
//  values     in   WORD_SIZE x NUM_CLASSES  unpacked array; values[i] = output neuron i
//  busy       out  1                        scan in progress; start ignored while high
//  done       out  1                        1-cycle pulse: class_out/max_value valid
//  class_out  out  CLASS_W                  index of max value; held until next accepted start
//  max_value  out  WORD_SIZE                value at class_out; held like class_out
//  margin     out  WORD_SIZE+1              only with FC_ARGMAX_MARGIN_EN, see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, class_out=0, max_value=0, margin=0; async assert, sync release.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: start=1 -> snap<=values, best<=values[0], best_idx<=0, idx<=1.
//         Next state is SCAN, or DONE if NUM_CLASSES==1.
//   SCAN: busy=1. If $signed(snap[idx]) > $signed(best), then best<=snap[idx] and best_idx<=idx.
//         idx<=idx+1. Leave for DONE after comparing idx==NUM_CLASSES-1.
//   DONE: done=1 for exactly one cycle. class_out<=best_idx and max_value<=best are registered on SCAN->DONE.
//         start=1 in DONE is accepted (back-to-back) with the same effect as in IDLE; otherwise go to IDLE.
//  Latency: start sampled at edge k -> done high in cycle after edge k+NUM_CLASSES-1 (10 cycles for defaults).
//  Snapshot: values may change after the start edge without affecting the running scan.
//  Ties: strict '>' compare, so the lowest index among equal maxima wins.
//  Compare is signed. 16'h8000 is the most negative value and never beats an earlier equal value.
//  start while busy: ignored, no queuing, no error flag.
//  Reset mid-scan: abort immediately. Outputs return to reset values and no done pulse is issued.
//  idx counter width is CLASS_W. It never wraps; the terminal value is NUM_CLASSES-1.
// CONFIGURATION
//  `FC_ARGMAX_MARGIN_EN defined:
//   - Also track second-best value (init: most negative word; runner-up updated when the best is displaced,
//     or when the new value > runner-up and does not beat the best).
//   - On DONE, margin = best - second as a WORD_SIZE+1 signed value (cannot overflow).
//   - For NUM_CLASSES==1, margin = 0. Ties give margin 0.
//  Undefined: no margin port, no second-best register; timing and other outputs identical.
// STRUCTURE
//  Shared package fc_pkg: WORD_SIZE, NUM_CLASSES, CLASS_W constants.
//  Also in fc_pkg: typedef logic signed [WORD_SIZE-1:0] fc_word_t; typedef enum {IDLE,SCAN,DONE} fc_argmax_state_t.
//  One natural sub-module: fc_max_compare, combinational.
//   Inputs: candidate, candidate index, best, best index (and second with the macro).
//   Outputs: updated best/index (and second).
//   Keeps the FSM file to control and registers only.
// TESTING
//  1. values = {0..9} with value[i]=i*16'h0100, start 1 cycle -> done exactly 10 cycles later, class_out=9, max_value=16'h0900.
//  2. All values = 16'hFFF0 except value[3]=16'hFFF8 -> class_out=3; all equal 16'h8000 -> class_out=0 (tie, signed).
//  3. Change values one cycle after start (value[7]=16'h7FFF) -> result reflects snapshot only.
//     Pulse start at cycles +3 and +5 while busy -> exactly one done.
//  4. Assert rst_n=0 at scan cycle 5 -> busy/done/class_out=0 at once.
//     Release, restart -> normal result, no stale done.
//  5. Back-to-back: start asserted in the DONE cycle -> busy next cycle.
//     Second done 10 cycles later with the new result. class_out holds between the two runs.
//  6. With FC_ARGMAX_MARGIN_EN: best=16'h7FFF, second=16'h8001 -> margin=17'h0FFFE.
//     With value[2]=value[5]=16'h0400 as the max -> class_out=2, margin=0.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared FC output-layer constants, word type and argmax FSM states.
package fc_pkg;
    localparam int WORD_SIZE   = 16;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = 4;
    typedef logic signed [WORD_SIZE-1:0] fc_word_t;
    typedef logic [CLASS_W-1:0] fc_idx_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} fc_argmax_state_t;
    localparam fc_word_t WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
endpackage

// File: rtl/fc_max_compare.sv
// fc_max_compare: one signed strict-greater step of the argmax scan (runner-up tracking with FC_ARGMAX_MARGIN_EN).
module fc_max_compare
    import fc_pkg::*;
(
    input  fc_word_t cand_i,
    input  fc_idx_t  cand_idx_i,
    input  fc_word_t best_i,
    input  fc_idx_t  best_idx_i,
`ifdef FC_ARGMAX_MARGIN_EN
    input  fc_word_t second_i,
    output fc_word_t second_o,
`endif
    output fc_word_t best_o,
    output fc_idx_t  best_idx_o
);
    logic gt;
    // strict compare keeps the lowest index on ties
    assign gt         = cand_i > best_i;
    assign best_o     = gt ? cand_i : best_i;
    assign best_idx_o = gt ? cand_idx_i : best_idx_i;
`ifdef FC_ARGMAX_MARGIN_EN
    assign second_o   = gt ? best_i : (cand_i > second_i ? cand_i : second_i);
`endif
endmodule

// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: snapshots the FC output neurons on start and scans them serially for the argmax.
// Optional FC_ARGMAX_MARGIN_EN adds a best-minus-runner-up margin output.
module fc_argmax_classifier
    import fc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] values [NUM_CLASSES],
    output logic                 busy,
    output logic                 done,
    output logic [CLASS_W-1:0]   class_out,
    output logic [WORD_SIZE-1:0] max_value
`ifdef FC_ARGMAX_MARGIN_EN
    ,
    output logic [WORD_SIZE:0]   margin
`endif
);
    fc_argmax_state_t     state_q, state_d;
    logic [WORD_SIZE-1:0] snap_q [NUM_CLASSES];
    fc_word_t             best_q, nxt_best;
    fc_idx_t              best_idx_q, nxt_idx, idx_q, class_q;
    fc_word_t             max_q;
    logic                 accept, last;

    assign accept = start && state_q != SCAN;
    assign last   = idx_q == CLASS_W'(NUM_CLASSES - 1);

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = (NUM_CLASSES == 1) ? DONE : SCAN;
        else
            state_d = (state_q == SCAN) ? (last ? DONE : SCAN) : IDLE;
    end

`ifdef FC_ARGMAX_MARGIN_EN
    fc_word_t            second_q, nxt_second;
    logic [WORD_SIZE:0]  margin_q;
    assign margin = margin_q;
`endif

    fc_max_compare u_cmp (
        .cand_i     (fc_word_t'(snap_q[idx_q])),
        .cand_idx_i (idx_q),
        .best_i     (best_q),
        .best_idx_i (best_idx_q),
`ifdef FC_ARGMAX_MARGIN_EN
        .second_i   (second_q),
        .second_o   (nxt_second),
`endif
        .best_o     (nxt_best),
        .best_idx_o (nxt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_q     <= '{default: '0};
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            class_q    <= '0;
            max_q      <= '0;
`ifdef FC_ARGMAX_MARGIN_EN
            second_q   <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                snap_q     <= values;
                best_q     <= fc_word_t'(values[0]);
                best_idx_q <= '0;
                idx_q      <= CLASS_W'(1);
`ifdef FC_ARGMAX_MARGIN_EN
                second_q   <= WORD_MIN;
`endif
            end else if (state_q == SCAN) begin
                best_q     <= nxt_best;
                best_idx_q <= nxt_idx;
                idx_q      <= last ? idx_q : idx_q + 1'b1;
`ifdef FC_ARGMAX_MARGIN_EN
                second_q   <= nxt_second;
`endif
            end
            // results only move when a scan completes, so they hold across a back-to-back restart
            if (state_q == SCAN && last) begin
                class_q  <= nxt_idx;
                max_q    <= nxt_best;
`ifdef FC_ARGMAX_MARGIN_EN
                margin_q <= {nxt_best[WORD_SIZE-1], nxt_best} - {nxt_second[WORD_SIZE-1], nxt_second};
`endif
            end else if (accept && NUM_CLASSES == 1) begin
                class_q  <= '0;
                max_q    <= fc_word_t'(values[0]);
`ifdef FC_ARGMAX_MARGIN_EN
                margin_q <= '0;
`endif
            end
        end
    end

    assign busy      = state_q == SCAN;
    assign done      = state_q == DONE;
    assign class_out = class_q;
    assign max_value = max_q;
endmodule

// File: tb/tb_fc_argmax_classifier.sv
// tb_fc_argmax_classifier: randomized and directed checks of the serial argmax against a reference model.
module tb_fc_argmax_classifier;
    localparam int N = 10;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [15:0] vals [N];
    logic        busy, done;
    logic [3:0]  class_out;
    logic [15:0] max_value;
`ifdef FC_ARGMAX_MARGIN_EN
    logic [16:0] margin;
`endif

    int n_vec = 0;
    int n_err = 0;

    int          e_cls;
    logic [15:0] e_max;
    logic [16:0] e_mg;

    always #5 clk = ~clk;

    fc_argmax_classifier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .values    (vals),
        .busy      (busy),
        .done      (done),
        .class_out (class_out),
`ifdef FC_ARGMAX_MARGIN_EN
        .margin    (margin),
`endif
        .max_value (max_value)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Maximum by value first, then the first position holding it; runner-up is the
    // largest of the remaining entries.
    task automatic ref_model(input logic [15:0] v [N], output int cls, output logic [15:0] mx,
                             output logic [16:0] mg);
        int m, s;
        m = $signed(v[0]);
        for (int i = 1; i < N; i++) m = ($signed(v[i]) > m) ? int'($signed(v[i])) : m;
        cls = 0;
        for (int i = N - 1; i >= 0; i--) if (int'($signed(v[i])) == m) cls = i;
        s = (N == 1) ? m : -32768;
        for (int j = 0; j < N; j++) if (j != cls && int'($signed(v[j])) > s) s = $signed(v[j]);
        mx = m[15:0];
        mg = 17'(m - s);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag, input int l0, output int lat);
        lat = l0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_class"}, 32'(class_out), 32'(e_cls));
        chk({tag, "_max"}, 32'(max_value), 32'(e_max));
`ifdef FC_ARGMAX_MARGIN_EN
        chk({tag, "_margin"}, 32'(margin), 32'(e_mg));
`endif
    endtask

    task automatic run_scan(input string tag);
        int lat;
        ref_model(vals, e_cls, e_max, e_mg);
        pulse_start();
        chk({tag, "_busy"}, 32'(busy), 1);
        wait_done(tag, 1, lat);
        chk({tag, "_lat"}, lat, N);
        check_result(tag);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 0);
    endtask

    initial begin
        int lat, nd, cls_a;
        logic [15:0] hold [N];
        for (int i = 0; i < N; i++) vals[i] = '0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_class", 32'(class_out), 0);
        chk("rst_max", 32'(max_value), 0);
        @(negedge clk);
        rst_n = 1;

        // ascending ramp
        for (int i = 0; i < N; i++) vals[i] = 16'(i * 16'h0100);
        run_scan("ramp");
        chk("ramp_cls9", 32'(class_out), 9);
        chk("ramp_max", 32'(max_value), 32'h0900);

        // signed negatives, and all-most-negative tie
        for (int i = 0; i < N; i++) vals[i] = 16'hFFF0;
        vals[3] = 16'hFFF8;
        run_scan("neg");
        chk("neg_cls3", 32'(class_out), 3);
        for (int i = 0; i < N; i++) vals[i] = 16'h8000;
        run_scan("min_tie");
        chk("min_tie_cls0", 32'(class_out), 0);

        // snapshot isolation and start ignored while busy
        for (int i = 0; i < N; i++) vals[i] = 16'($urandom_range(0, 16'h3FFF));
        ref_model(vals, e_cls, e_max, e_mg);
        pulse_start();
        vals[7] = 16'h7FFF;
        nd = 0;
        lat = 0;
        for (int c = 1; c <= 25; c++) begin
            start = (c == 3 || c == 5);
            if (done) begin
                nd++;
                lat = c;
                check_result("snap");
            end
            @(negedge clk);
        end
        start = 0;
        chk("snap_ndone", nd, 1);
        chk("snap_lat", lat, N);

        // reset in mid-scan
        for (int i = 0; i < N; i++) vals[i] = 16'($urandom);
        pulse_start();
        repeat (4) @(negedge clk);
        rst_n = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_class", 32'(class_out), 0);
        chk("arst_max", 32'(max_value), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("arst_stale_done", nd, 0);
        run_scan("after_rst");

        // back-to-back start in the DONE cycle
        for (int i = 0; i < N; i++) vals[i] = 16'(i * 16'h0100);
        pulse_start();
        wait_done("b2b_a", 1, lat);
        cls_a = class_out;
        chk("b2b_a_cls", cls_a, 9);
        for (int i = 0; i < N; i++) hold[i] = 16'($urandom_range(0, 16'h0FFF));
        hold[2] = 16'h5000;
        vals = hold;
        ref_model(vals, e_cls, e_max, e_mg);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_hold1", 32'(class_out), 32'(cls_a));
        repeat (4) @(negedge clk);
        chk("b2b_hold5", 32'(class_out), 32'(cls_a));
        wait_done("b2b_b", 5, lat);
        chk("b2b_lat", lat, N);
        check_result("b2b_b");
        chk("b2b_cls2", 32'(class_out), 2);

`ifdef FC_ARGMAX_MARGIN_EN
        for (int i = 0; i < N; i++) vals[i] = 16'h8000;
        vals[4] = 16'h7FFF;
        vals[8] = 16'h8001;
        run_scan("mg_wide");
        chk("mg_wide_val", 32'(margin), 32'h0FFFE);
        for (int i = 0; i < N; i++) vals[i] = 16'h0100;
        vals[2] = 16'h0400;
        vals[5] = 16'h0400;
        run_scan("mg_tie");
        chk("mg_tie_val", 32'(margin), 0);
        chk("mg_tie_cls", 32'(class_out), 2);
`endif

        // randomized sweep, every third vector drawn from a tie-prone small set
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: hold[i] = 16'h8000;
                    1: hold[i] = 16'hFFFF;
                    2: hold[i] = 16'h0000;
                    default: hold[i] = 16'h7FFF;
                endcase
                if (t % 3 != 0) hold[i] = 16'($urandom);
            end
            vals = hold;
            run_scan($sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
